usb_fs_rx: RTL
==============

USB_FS_RX -- requirements
Module: usb_fs_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 4, meaning clk cycles per USB full-speed bit (clk = 48 MHz for 12 Mb/s).
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port ena, input, 1: block enable; low forces IDLE and zeroes all pulse outputs.
REQ-005 SHALL have port dp_i, input, 1: raw D+ pad input, asynchronous.
REQ-006 SHALL have port dn_i, input, 1: raw D- pad input, asynchronous.
REQ-007 SHALL have port line_state, output, 2: synchronized {dp,dn}; 10=J, 01=K, 00=SE0, 11=SE1.
REQ-008 SHALL have port rx_active, output, 1: high from SYNC completion to EOP or error.
REQ-009 SHALL have port rx_data, output, 8: last assembled byte, LSB received first.
REQ-010 SHALL have port rx_valid, output, 1: one-cycle strobe, rx_data new.
REQ-011 SHALL have port rx_eop, output, 1: one-cycle strobe at packet end.
REQ-012 SHALL have port rx_error, output, 1: one-cycle strobe on stuff error or non-byte-aligned EOP.
REQ-013 SHALL have port rx_crc_ok, output, 1: CRC16 result, valid from rx_eop until next SYNC.

Function
REQ-014 SHALL pass dp_i/dn_i through two flops before any use; line_state is the second flop.
REQ-015 SHALL reset a mod-OVERSAMPLE phase counter to 0 on every J<->K change; sample point is phase OVERSAMPLE/2.
REQ-016 SHALL NRZI-decode at each sample point: bit 1 if sampled state equals previous sample, else 0.
REQ-017 SHALL implement states IDLE, SYNC, DATA, ABORT.
REQ-018 IDLE->SYNC on first sampled K.
REQ-019 SYNC: counts decoded 0s; a 1 after >=5 zeros -> DATA with rx_active=1 next cycle; a 1 after <5 zeros, or SE0, -> IDLE.
REQ-020 DATA: after six consecutive 1s the next bit SHALL be dropped if 0; if 1, rx_error pulse, rx_active=0, go ABORT.
REQ-021 DATA: 8th non-stuff bit -> rx_data updated and rx_valid pulsed the cycle after that sample point.
REQ-022 DATA: SE0 sampled then J sampled -> rx_eop pulse, rx_active=0 same cycle, -> IDLE; rx_error also pulses if 1-7 partial bits pending (partial bits discarded).
REQ-023 ABORT: ignore bits until SE0 followed by J, then -> IDLE without rx_eop.
REQ-024 SE1 in any state SHALL be treated as SE0.
REQ-025 ena deasserted mid-packet SHALL drop to IDLE next cycle with no rx_eop/rx_error.

Reset
REQ-026 rst_n low SHALL asynchronously set state IDLE, line_state=10, rx_data=0, rx_active=rx_valid=rx_eop=rx_error=0, rx_crc_ok=0, counters 0.
REQ-027 Reset mid-packet SHALL discard the packet; reception resumes only after a new SYNC.

Configuration
REQ-028 Macro USB_RX_CRC16_EN defined: CRC16 (poly 0x8005, init 0xFFFF, LSB-first) SHALL run over all bits after the first byte; at rx_eop rx_crc_ok=1 iff >=3 bytes received and residual == 0x800D; cleared at SYNC.
REQ-029 Macro USB_RX_CRC16_EN undefined: no CRC logic; rx_crc_ok SHALL be constant 1 after reset.

Structure
REQ-030 Package usbdev_pkg SHALL hold line-state encodings (J,K,SE0,SE1), the rx state enum, CRC16 poly/init/residual constants.
REQ-031 Sub-module usb_fs_rx_dpll SHALL contain synchronizer, phase counter and sample strobe; NRZI, unstuff, FSM, CRC live in usb_fs_rx.

Verification
REQ-032 ACK packet: SYNC + PID 0xD2 + EOP (2 bit SE0, J) -> one rx_valid with rx_data=0xD2, then rx_eop, rx_error=0.
REQ-033 DATA0 C3 00 00 (zero-length, CRC 0x0000) -> three rx_valid (C3,00,00), rx_eop, rx_crc_ok=1 (with macro); flip one CRC bit -> rx_crc_ok=0.
REQ-034 Byte 0xFF 0xFF with stuffed zeros -> rx_data=0xFF twice, no error; remove one stuffed 0 -> rx_error pulse, rx_active=0, no rx_eop.
REQ-035 EOP after 12 data bits -> rx_valid once, rx_eop and rx_error pulse same cycle.
REQ-036 rst_n low mid-byte of PID 0x69 then release, then clean ACK -> only 0xD2 reported, all outputs at reset values during reset.
REQ-037 Bit period jitter +/-1 clk on each edge (OVERSAMPLE=4) -> packet of REQ-033 received error-free.

Source files
------------

// File: rtl/usbdev_pkg.sv
// Shared USB full-speed receive definitions: line-state encodings, receiver
// state enum and CRC16 constants/helpers.
package usbdev_pkg;

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SYNC,
        RX_DATA,
        RX_ABORT
    } rx_state_t;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    // SE1 is illegal on the bus and is handled exactly like SE0
    function automatic logic is_se0(input logic [1:0] ls);
        return (ls == LS_SE0) || (ls == LS_SE1);
    endfunction

    // One serial CRC16 step; register bit i holds the x^i coefficient
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        return {crc[14:0], 1'b0} ^ (((b ^ crc[15]) != 1'b0) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/usb_fs_rx_dpll.sv
// Pad synchronizer and bit-clock recovery: re-phases on every J<->K edge and
// emits one sample strobe per bit period together with the sampled line state.
module usb_fs_rx_dpll
    import usbdev_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dp_i,
    input  logic       dn_i,
    output logic [1:0] line_state,
    output logic       sample,
    output logic [1:0] sample_ls
);

    localparam int unsigned PW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [PW-1:0] HALF = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] LAST = PW'(OVERSAMPLE - 1);

    logic [1:0]    meta;
    logic [1:0]    line_q;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_c;
    logic          edge_c;

    // The cycle a J<->K change reaches line_state is phase 0
    always_comb begin
        edge_c  = ((line_state == LS_J) && (line_q == LS_K)) ||
                  ((line_state == LS_K) && (line_q == LS_J));
        phase_c = edge_c ? '0 : phase;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta       <= LS_J;
            line_state <= LS_J;
            line_q     <= LS_J;
            phase      <= '0;
            sample     <= 1'b0;
            sample_ls  <= LS_J;
        end else begin
            meta       <= {dp_i, dn_i};
            line_state <= meta;
            line_q     <= line_state;
            phase      <= (phase_c == LAST) ? '0 : phase_c + PW'(1);
            sample     <= (phase_c == HALF);
            sample_ls  <= line_state;
        end
    end

endmodule

// File: rtl/usb_fs_rx.sv
// USB full-speed receiver: NRZI decode, SYNC detect, bit unstuffing, byte
// assembly and EOP handling. Optional CRC16 check under USB_RX_CRC16_EN.
module usb_fs_rx
    import usbdev_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       dp_i,
    input  logic       dn_i,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_eop,
    output logic       rx_error,
    output logic       rx_crc_ok
);

    logic       sample;
    logic [1:0] sample_ls;

    usb_fs_rx_dpll #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_dpll (
        .clk        (clk),
        .rst_n      (rst_n),
        .dp_i       (dp_i),
        .dn_i       (dn_i),
        .line_state (line_state),
        .sample     (sample),
        .sample_ls  (sample_ls)
    );

    rx_state_t  state, state_n;
    logic [1:0] prev_ls, prev_ls_n;
    logic [2:0] zero_cnt, zero_n;
    logic [2:0] ones_cnt, ones_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shift, shift_n;
    logic       se0_seen, se0_n;
    logic [7:0] data_n;
    logic       active_n, valid_n, eop_n, error_n, crc_ok_n;
    logic       se0_c, bit_c;
`ifdef USB_RX_CRC16_EN
    logic [15:0] crc, crc_n;
    logic [1:0]  byte_cnt, byte_n;
`endif

    always_comb begin
        state_n   = state;
        prev_ls_n = prev_ls;
        zero_n    = zero_cnt;
        ones_n    = ones_cnt;
        bit_n     = bit_cnt;
        shift_n   = shift;
        se0_n     = se0_seen;
        data_n    = rx_data;
        active_n  = rx_active;
        valid_n   = 1'b0;
        eop_n     = 1'b0;
        error_n   = 1'b0;
`ifdef USB_RX_CRC16_EN
        crc_n     = crc;
        byte_n    = byte_cnt;
        crc_ok_n  = rx_crc_ok;
`else
        crc_ok_n  = 1'b1;
`endif
        se0_c = is_se0(sample_ls);
        bit_c = (sample_ls == prev_ls);

        if (!ena) begin
            state_n  = RX_IDLE;
            active_n = 1'b0;
            se0_n    = 1'b0;
        end else if (sample) begin
            prev_ls_n = sample_ls;
            case (state)
                RX_IDLE: begin
                    // The J->K transition itself is the first SYNC zero
                    if (sample_ls == LS_K) begin
                        state_n = RX_SYNC;
                        zero_n  = 3'd1;
`ifdef USB_RX_CRC16_EN
                        crc_ok_n = 1'b0;
`endif
                    end
                end
                RX_SYNC: begin
                    if (se0_c) begin
                        state_n = RX_IDLE;
                    end else if (!bit_c) begin
                        zero_n = (zero_cnt == 3'd7) ? zero_cnt : zero_cnt + 3'd1;
                    end else if (zero_cnt >= 3'd5) begin
                        // SYNC's closing 1 already counts towards the stuffing run
                        state_n  = RX_DATA;
                        active_n = 1'b1;
                        ones_n   = 3'd1;
                        bit_n    = 3'd0;
                        se0_n    = 1'b0;
`ifdef USB_RX_CRC16_EN
                        crc_n    = CRC16_INIT;
                        byte_n   = 2'd0;
`endif
                    end else begin
                        state_n = RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (se0_c) begin
                        se0_n = 1'b1;
                    end else if (se0_seen) begin
                        se0_n    = 1'b0;
                        active_n = 1'b0;
                        if (sample_ls == LS_J) begin
                            state_n = RX_IDLE;
                            eop_n   = 1'b1;
                            error_n = (bit_cnt != 3'd0);
`ifdef USB_RX_CRC16_EN
                            crc_ok_n = (byte_cnt == 2'd3) && (crc == CRC16_RESIDUAL);
`endif
                        end else begin
                            state_n = RX_ABORT;
                            error_n = 1'b1;
                        end
                    end else if (ones_cnt == 3'd6) begin
                        if (bit_c) begin
                            state_n  = RX_ABORT;
                            error_n  = 1'b1;
                            active_n = 1'b0;
                        end else begin
                            ones_n = 3'd0;
                        end
                    end else begin
                        ones_n  = bit_c ? ones_cnt + 3'd1 : 3'd0;
                        shift_n = {bit_c, shift[7:1]};
                        bit_n   = bit_cnt + 3'd1;
`ifdef USB_RX_CRC16_EN
                        if (byte_cnt != 2'd0) begin
                            crc_n = crc16_step(crc, bit_c);
                        end
`endif
                        if (bit_cnt == 3'd7) begin
                            data_n  = shift_n;
                            valid_n = 1'b1;
`ifdef USB_RX_CRC16_EN
                            byte_n  = (byte_cnt == 2'd3) ? byte_cnt : byte_cnt + 2'd1;
`endif
                        end
                    end
                end
                RX_ABORT: begin
                    if (se0_c) begin
                        se0_n = 1'b1;
                    end else if (se0_seen) begin
                        se0_n = 1'b0;
                        if (sample_ls == LS_J) begin
                            state_n = RX_IDLE;
                        end
                    end
                end
                default: state_n = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            prev_ls   <= LS_J;
            zero_cnt  <= 3'd0;
            ones_cnt  <= 3'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            se0_seen  <= 1'b0;
            rx_data   <= 8'h00;
            rx_active <= 1'b0;
            rx_valid  <= 1'b0;
            rx_eop    <= 1'b0;
            rx_error  <= 1'b0;
            rx_crc_ok <= 1'b0;
`ifdef USB_RX_CRC16_EN
            crc       <= CRC16_INIT;
            byte_cnt  <= 2'd0;
`endif
        end else begin
            state     <= state_n;
            prev_ls   <= prev_ls_n;
            zero_cnt  <= zero_n;
            ones_cnt  <= ones_n;
            bit_cnt   <= bit_n;
            shift     <= shift_n;
            se0_seen  <= se0_n;
            rx_data   <= data_n;
            rx_active <= active_n;
            rx_valid  <= valid_n;
            rx_eop    <= eop_n;
            rx_error  <= error_n;
            rx_crc_ok <= crc_ok_n;
`ifdef USB_RX_CRC16_EN
            crc       <= crc_n;
            byte_cnt  <= byte_n;
`endif
        end
    end

endmodule
